// File: rtl/sdram_log_sequencer.sv
// Client side of the sdram_interface command port: buffers log words, writes them at an auto-incrementing
// linear {bank,row,col} pointer, and serves one outstanding random-address readback at a time.
`timescale 1ns/1ps
module sdram_log_sequencer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 63,
  parameter bit          WRAP_EN    = 1'b0,
  parameter logic [23:0] PTR_INIT   = 24'h000000
) (
  input  logic        CLK_48MHZ,
  input  logic        RESET_N,
  input  logic [15:0] WR_DATA,
  input  logic        WR_VALID,
  output logic        WR_READY,
  input  logic        RD_REQ,
  input  logic [23:0] RD_ADDR,
  output logic        RD_BUSY,
  output logic        RD_VALID,
  output logic [15:0] RD_DATA,
  output logic [1:0]  SD_CMD,
  output logic [1:0]  SD_BANK,
  output logic [12:0] SD_ROW,
  output logic [8:0]  SD_COL,
  output logic [15:0] SD_DIN,
  input  logic        SD_STATUS,
  input  logic [15:0] SD_DATA_READ,
  output logic [23:0] WR_PTR,
  output logic [5:0]  FIFO_LEVEL,
  output logic        MEM_FULL,
  output logic        ERR
);

  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam logic [5:0]  DEPTH      = 6'(FIFO_DEPTH);
  localparam logic [5:0]  TMO        = 6'(TIMEOUT);
  localparam logic [1:0]  CMD_IDLE   = 2'd0;
  localparam logic [1:0]  CMD_READ   = 2'd1;
  localparam logic [1:0]  CMD_WRITE  = 2'd2;
  localparam logic [23:0] PTR_LAST   = 24'hFFFFFF;
  localparam logic [15:0] ABORT_WORD = 16'hDEAD;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_WR_WAIT  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_nxt_s;
  logic [5:0]    tmo_cnt_r;
  logic          tmo_hit_s;

  logic [15:0]   fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0] fifo_rd_idx_r;
  logic [AW-1:0] fifo_wr_idx_r;
  logic [5:0]    level_r;
  logic [5:0]    level_nxt_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          push_s;
  logic          pop_s;

  logic [23:0]   wr_ptr_r;
  logic          mem_full_r;
  logic          mem_full_nxt_s;
  logic          wr_ready_r;

  logic          rd_busy_r;
  logic          rd_valid_r;
  logic [15:0]   rd_data_r;
  logic [23:0]   rd_addr_r;
  logic          rd_done_s;
  logic          rd_abort_s;

  logic          err_r;
  logic          err_set_s;

  logic [1:0]    sd_cmd_r;
  logic [1:0]    sd_cmd_nxt_s;
  logic [23:0]   sd_addr_r;
  logic [23:0]   sd_addr_nxt_s;
  logic [15:0]   sd_din_r;
  logic [15:0]   sd_din_nxt_s;

  assign fifo_full_s    = (level_r == DEPTH);
  assign fifo_empty_s   = (level_r == 6'd0);
  assign push_s         = WR_VALID & wr_ready_r;
  assign level_nxt_s    = level_r + {5'd0, push_s} - {5'd0, pop_s};
  assign mem_full_nxt_s = mem_full_r | (pop_s & (wr_ptr_r == PTR_LAST) & !WRAP_EN);
  assign tmo_hit_s      = (tmo_cnt_r == TMO);

  // Next-state decode; a phase stuck at the timeout is abandoned back to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    rd_done_s   = 1'b0;
    rd_abort_s  = 1'b0;
    err_set_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // A full FIFO goes first, unless the pointer is exhausted and writes can never drain it.
        if (!SD_STATUS) begin
          state_nxt_s = ST_IDLE;
        end else if (rd_busy_r && (!fifo_full_s || mem_full_r)) begin
          state_nxt_s = ST_RD_ISSUE;
        end else if (!fifo_empty_s && !mem_full_r) begin
          state_nxt_s = ST_WR_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WR_ISSUE: begin
        if (!SD_STATUS) begin
          state_nxt_s = ST_WR_WAIT;
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_IDLE;
          err_set_s   = 1'b1;
        end else begin
          state_nxt_s = ST_WR_ISSUE;
        end
      end
      ST_WR_WAIT: begin
        if (SD_STATUS) begin
          state_nxt_s = ST_IDLE;
          pop_s       = 1'b1;
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_IDLE;
          err_set_s   = 1'b1;
        end else begin
          state_nxt_s = ST_WR_WAIT;
        end
      end
      ST_RD_ISSUE: begin
        if (!SD_STATUS) begin
          state_nxt_s = ST_RD_WAIT;
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_IDLE;
          err_set_s   = 1'b1;
          rd_abort_s  = 1'b1;
        end else begin
          state_nxt_s = ST_RD_ISSUE;
        end
      end
      ST_RD_WAIT: begin
        if (SD_STATUS) begin
          state_nxt_s = ST_IDLE;
          rd_done_s   = 1'b1;
        end else if (tmo_hit_s) begin
          state_nxt_s = ST_IDLE;
          err_set_s   = 1'b1;
          rd_abort_s  = 1'b1;
        end else begin
          state_nxt_s = ST_RD_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Command-port drive for the state being entered, so the registered outputs track the FSM.
  always_comb begin
    sd_cmd_nxt_s  = CMD_IDLE;
    sd_addr_nxt_s = 24'd0;
    sd_din_nxt_s  = 16'd0;
    case (state_nxt_s)
      ST_WR_ISSUE: begin
        sd_cmd_nxt_s  = CMD_WRITE;
        sd_addr_nxt_s = wr_ptr_r;
        sd_din_nxt_s  = fifo_mem_r[fifo_rd_idx_r];
      end
      ST_WR_WAIT: begin
        sd_cmd_nxt_s  = CMD_IDLE;
        sd_addr_nxt_s = wr_ptr_r;
        sd_din_nxt_s  = fifo_mem_r[fifo_rd_idx_r];
      end
      ST_RD_ISSUE: begin
        sd_cmd_nxt_s  = CMD_READ;
        sd_addr_nxt_s = rd_addr_r;
        sd_din_nxt_s  = 16'd0;
      end
      ST_RD_WAIT: begin
        sd_cmd_nxt_s  = CMD_IDLE;
        sd_addr_nxt_s = rd_addr_r;
        sd_din_nxt_s  = 16'd0;
      end
      default: begin
        sd_cmd_nxt_s  = CMD_IDLE;
        sd_addr_nxt_s = 24'd0;
        sd_din_nxt_s  = 16'd0;
      end
    endcase
  end

  // State register and per-phase timeout counter, cleared on every state change.
  always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r   <= ST_IDLE;
      tmo_cnt_r <= 6'd0;
    end else begin
      state_r <= state_nxt_s;
      if ((state_nxt_s != state_r) || (state_r == ST_IDLE)) begin
        tmo_cnt_r <= 6'd0;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + 6'd1;
      end
    end
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge CLK_48MHZ) begin
    if (push_s) begin
      fifo_mem_r[fifo_wr_idx_r] <= WR_DATA;
    end
  end

  // FIFO indices, occupancy and the registered ready flag.
  always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      fifo_wr_idx_r <= '0;
      fifo_rd_idx_r <= '0;
      level_r       <= 6'd0;
      wr_ready_r    <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_wr_idx_r <= fifo_wr_idx_r + AW'(1);
      end
      if (pop_s) begin
        fifo_rd_idx_r <= fifo_rd_idx_r + AW'(1);
      end
      level_r    <= level_nxt_s;
      wr_ready_r <= (level_nxt_s != DEPTH) && !mem_full_nxt_s;
    end
  end

  // Linear write pointer: a plain 24-bit increment carries col into row and row into bank.
  always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_r   <= PTR_INIT;
      mem_full_r <= 1'b0;
    end else begin
      if (pop_s) begin
        if (wr_ptr_r != PTR_LAST) begin
          wr_ptr_r <= wr_ptr_r + 24'd1;
        end else if (WRAP_EN) begin
          wr_ptr_r <= 24'd0;
        end else begin
          wr_ptr_r <= wr_ptr_r;
        end
      end
      mem_full_r <= mem_full_nxt_s;
    end
  end

  // Single-outstanding readback: latch request when free, return data or the abort word.
  always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_busy_r  <= 1'b0;
      rd_valid_r <= 1'b0;
      rd_data_r  <= 16'd0;
      rd_addr_r  <= 24'd0;
    end else begin
      rd_valid_r <= 1'b0;
      if (!rd_busy_r) begin
        if (RD_REQ) begin
          rd_busy_r <= 1'b1;
          rd_addr_r <= RD_ADDR;
        end
      end else if (rd_done_s) begin
        rd_busy_r  <= 1'b0;
        rd_valid_r <= 1'b1;
        rd_data_r  <= SD_DATA_READ;
      end else if (rd_abort_s) begin
        rd_busy_r  <= 1'b0;
        rd_valid_r <= 1'b1;
        rd_data_r  <= ABORT_WORD;
      end
    end
  end

  // Registered command-port outputs and the sticky timeout flag.
  always_ff @(posedge CLK_48MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      sd_cmd_r  <= CMD_IDLE;
      sd_addr_r <= 24'd0;
      sd_din_r  <= 16'd0;
      err_r     <= 1'b0;
    end else begin
      sd_cmd_r  <= sd_cmd_nxt_s;
      sd_addr_r <= sd_addr_nxt_s;
      sd_din_r  <= sd_din_nxt_s;
      err_r     <= err_r | err_set_s;
    end
  end

  assign WR_READY   = wr_ready_r;
  assign RD_BUSY    = rd_busy_r;
  assign RD_VALID   = rd_valid_r;
  assign RD_DATA    = rd_data_r;
  assign SD_CMD     = sd_cmd_r;
  assign SD_BANK    = sd_addr_r[23:22];
  assign SD_ROW     = sd_addr_r[21:9];
  assign SD_COL     = sd_addr_r[8:0];
  assign SD_DIN     = sd_din_r;
  assign WR_PTR     = wr_ptr_r;
  assign FIFO_LEVEL = level_r;
  assign MEM_FULL   = mem_full_r;
  assign ERR        = err_r;

endmodule
